// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word lanes plus an MMIO console TX FIFO.
// Optional DMEM_MISALIGN_TRAP_EN: flag and suppress misaligned accesses instead of aligning them.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [1:0]  dmem_width,
    input  logic        dmem_zero_ext,
    input  logic        dmem_read,
    input  logic        dmem_write,
    output logic [31:0] dmem_rdata,
    output logic        misalign,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] head, tail;
    logic [FW:0]   count;
    logic          overflow;

    logic          is_byte, is_half, is_mmio, do_access;
    logic [1:0]    lo, mmio_off;
    logic [AW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   wlanes, status, src, shifted, ext;
    logic [31:0]   cnt32;
    logic [3:0]    cnt_sat;
    logic          full, empty, pop, push_req, push_ok, ovf_set, clr_ovf, ram_we, load_en;

    assign is_byte  = (dmem_width == 2'd0);
    assign is_half  = (dmem_width == 2'd1);
    assign is_mmio  = (dmem_addr[31:4] == MMIO_BASE[31:4]);
    assign word_idx = dmem_addr[AW+1:2];
    assign mmio_off = dmem_addr[3:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    assign mis       = (is_half && dmem_addr[0]) || (!is_byte && !is_half && dmem_addr[1:0] != 2'b00);
    assign lo        = dmem_addr[1:0];
    assign do_access = !mis;
`else
    // Drop the address bits below the access size so every access is naturally aligned.
    assign lo        = is_byte ? dmem_addr[1:0] : is_half ? {dmem_addr[1], 1'b0} : 2'b00;
    assign do_access = 1'b1;
`endif

    always_comb begin
        be     = 4'b1111;
        wlanes = dmem_wdata;
        if (is_byte) begin
            be     = 4'b0001 << lo;
            wlanes = {4{dmem_wdata[7:0]}};
        end else if (is_half) begin
            be     = lo[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{dmem_wdata[15:0]}};
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == (FW+1)'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = tx_valid ? fifo[head] : 8'h00;
    assign pop      = tx_valid && tx_ready;

    assign push_req = dmem_write && do_access && is_mmio && (mmio_off == 2'd0);
    assign clr_ovf  = dmem_write && do_access && is_mmio && (mmio_off == 2'd1);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ram_we   = dmem_write && do_access && !is_mmio && rst_n;
    assign load_en  = dmem_read && do_access;

    assign cnt32   = 32'(count);
    assign cnt_sat = (cnt32 > 32'd15) ? 4'hF : 4'(cnt32);
    assign status  = {25'b0, overflow, empty, full, cnt_sat};

    always_comb begin
        if (is_mmio) src = (mmio_off == 2'd1) ? status : 32'h0;
        else         src = mem[word_idx];
        shifted = src >> {lo, 3'b000};
        if (is_byte)      ext = dmem_zero_ext ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
        else if (is_half) ext = dmem_zero_ext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        else              ext = shifted;
    end

    // RAM contents survive reset; only the write is gated by it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && be[i]) mem[word_idx][i*8 +: 8] <= wlanes[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (push_ok && rst_n) fifo[tail] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_rdata <= 32'h0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (load_en) dmem_rdata <= ext;
            if (push_ok) tail <= tail + 1'b1;
            if (pop)     head <= head + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr_ovf)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= (dmem_read || dmem_write) && mis;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes/extension, MMIO TX FIFO, reset and alignment.
module tb_dmem_responder;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_width;
    logic        dmem_zero_ext, dmem_read, dmem_write;
    logic        misalign, tx_valid, tx_ready;
    logic [7:0]  tx_data;

    int n_run = 0;
    int n_fail = 0;

    dmem_responder dut (
        .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_width(dmem_width), .dmem_zero_ext(dmem_zero_ext), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_rdata(dmem_rdata), .misalign(misalign),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        dmem_addr = a; dmem_wdata = d; dmem_width = w; dmem_write = 1'b1;
        tick();
        dmem_write = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] w,
                      input logic z, input logic [31:0] exp);
        dmem_addr = a; dmem_width = w; dmem_zero_ext = z; dmem_read = 1'b1;
        tick();
        dmem_read = 1'b0;
        chk(tag, dmem_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_width = 2'd2;
        dmem_zero_ext = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        rst_n = 1'b1;
        tick();
        ld("rst_status", MB + 4, 2'd2, 1'b0, 32'h20);

        // RAM lanes and extension
        st(32'h100, 32'hDEADBEEF, 2'd2);
        ld("ldb_sext_103", 32'h103, 2'd0, 1'b0, 32'hFFFFFFDE);
        ld("ldh_zext_100", 32'h100, 2'd1, 1'b1, 32'h0000BEEF);
        ld("ldh_sext_102", 32'h102, 2'd1, 1'b0, 32'hFFFFDEAD);
        ld("ldw_rsv3",     32'h100, 2'd3, 1'b0, 32'hDEADBEEF);
        st(32'h101, 32'h0000005A, 2'd0);
        ld("ldw_after_sb", 32'h100, 2'd2, 1'b0, 32'hDEAD5AEF);
        ld("ldw_alias",    32'h1100, 2'd2, 1'b0, 32'hDEAD5AEF);
        st(32'h102, 32'h0000CAFE, 2'd1);
        ld("ldw_after_sh", 32'h100, 2'd2, 1'b0, 32'hCAFE5AEF);

        // read-before-write, then hold while idle
        dmem_addr = 32'h100; dmem_wdata = 32'h11223344; dmem_width = 2'd2;
        dmem_read = 1'b1; dmem_write = 1'b1;
        tick();
        dmem_read = 1'b0; dmem_write = 1'b0;
        chk("rbw_old", dmem_rdata, 32'hCAFE5AEF);
        tick();
        chk("idle_hold", dmem_rdata, 32'hCAFE5AEF);
        ld("rbw_new", 32'h100, 2'd2, 1'b0, 32'h11223344);

        // fill FIFO, overflow, clear
        for (int i = 0; i < 8; i++) st(MB, 32'h41 + i, 2'd0);
        ld("st_full", MB + 4, 2'd2, 1'b0, 32'h18);
        chk("head_41", {24'b0, tx_data}, 32'h41);
        st(MB, 32'h49, 2'd0);
        ld("st_ovf", MB + 4, 2'd2, 1'b0, 32'h58);
        ld("st_ovf_byte_sext", MB + 4, 2'd0, 1'b0, 32'h58);
        st(MB + 4, 32'h0, 2'd2);
        ld("st_clr", MB + 4, 2'd2, 1'b0, 32'h18);
        ld("mmio_8_zero", MB + 8, 2'd2, 1'b0, 32'h0);

        // push and pop on a full FIFO
        tx_ready = 1'b1;
        st(MB, 32'h49, 2'd0);
        tx_ready = 1'b0;
        ld("full_pushpop", MB + 4, 2'd2, 1'b0, 32'h18);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h42 + 8'(i)});
            tick();
        end
        chk("drained_valid", {31'b0, tx_valid}, 32'h0);
        ld("drained_status", MB + 4, 2'd2, 1'b0, 32'h20);

        // push into an empty FIFO while ready: visible next cycle, popped after
        st(MB, 32'h77, 2'd0);
        chk("empty_push_vis", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h77});
        tick();
        chk("empty_push_pop", {31'b0, tx_valid}, 32'h0);

        // reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) st(MB, 32'h61 + i, 2'd0);
        ld("pre_rst_status", MB + 4, 2'd2, 1'b0, 32'h03);
        tx_ready = 1'b1;
        tick();
        chk("pre_rst_head", {24'b0, tx_data}, 32'h62);
        rst_n = 1'b0;
        dmem_addr = 32'h100; dmem_width = 2'd2; dmem_wdata = 32'hFFFF0000; dmem_write = 1'b1;
        tick();
        dmem_write = 1'b0;
        chk("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
        chk("mid_rst_rdata", dmem_rdata, 32'h0);
        rst_n = 1'b1;
        tx_ready = 1'b0;
        ld("post_rst_status", MB + 4, 2'd2, 1'b0, 32'h20);
        ld("rst_discards_st", 32'h100, 2'd2, 1'b0, 32'h11223344);

        // misaligned word store
        dmem_addr = 32'h102; dmem_wdata = 32'h12345678; dmem_width = 2'd2; dmem_write = 1'b1;
        tick();
        dmem_write = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
        tick();
        chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
        ld("mis_suppressed", 32'h100, 2'd2, 1'b0, 32'h11223344);
`else
        chk("mis_tied0", {31'b0, misalign}, 32'h0);
        ld("mis_aligned_st", 32'h100, 2'd2, 1'b0, 32'h12345678);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the CPU's memory/branch-stage load/store interface. It serves `read`/`write` requests as a synchronous word-organised RAM with byte/half/word lanes and sign/zero extension. It also decodes a small MMIO window holding a console transmit FIFO with a valid/ready drain port. Read data is registered, so it is valid for the writeback stage one clock after the request.

## Interface

Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'h8000_0000: base of the 16-byte MMIO window.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `posedge clk`.
- `dmem_addr`  in  32  byte address; the ALU result.
- `dmem_wdata`  in  32  store data; rs2 value, right-aligned.
- `dmem_width`  in  2  access size: 0 byte, 1 half, 2 word; 3 is reserved and treated as word.
- `dmem_zero_ext`  in  1  1 zero-extends load results, 0 sign-extends.
- `dmem_read`  in  1  load request.
- `dmem_write`  in  1  store request.
- `dmem_rdata`  out  32  registered, extended load result.
- `misalign`  out  1  registered one-cycle pulse marking a misaligned access.
- `tx_data`  out  8  head of the TX FIFO.
- `tx_valid`  out  1  TX FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head byte.

## Operation

Address decode:
- An address is MMIO when `dmem_addr[31:4] == MMIO_BASE[31:4]`.
- Every other address selects RAM word `dmem_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored (aliasing).

Stores (`dmem_write`=1):
- RAM byte enables are derived from the width and `dmem_addr[1:0]`.
  - Byte: lane `a[1:0]` receives `wdata[7:0]`.
  - Half: lanes `a[1]*2` and `a[1]*2+1` receive `wdata[15:0]`.
  - Word: all four lanes.
- MMIO offset 0x0 (TXDATA): pushes `wdata[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and `overflow` is set.
- MMIO offset 0x4 (STATUS): any store clears `overflow`.
- Stores to MMIO offsets 0x8 and 0xC have no effect.

Loads (`dmem_read`=1):
- RAM: the addressed lane(s) are right-aligned, then sign- or zero-extended per `dmem_zero_ext`.
- MMIO offset 0x4 returns STATUS:
  - bits [3:0]: `count`, saturating at 15.
  - bit 4: `full`.
  - bit 5: `empty`.
  - bit 6: `overflow`.
  - all other bits 0.
- All other MMIO offsets return 0.
- Extension is applied to MMIO reads as well.
- When neither `read` nor `write` is asserted, `dmem_rdata` holds its previous value.

Simultaneous `read` and `write`:
- The write is performed.
- `dmem_rdata` returns the pre-write contents (read-before-write).

TX FIFO:
- Circular buffer with head and tail pointers plus a count of width log2(FIFO_DEPTH)+1.
- A pop occurs when `tx_valid && tx_ready`.
- Push and pop in the same cycle:
  - When the FIFO is full, both occur and the count is unchanged; the pop frees the slot before the push, so no overflow is flagged.
  - When the FIFO is empty, the new byte is not visible until the next cycle. `tx_valid` rises one cycle after the push.
- Pointers wrap modulo FIFO_DEPTH.

Reset (`rst_n`=0 at a posedge):
- Outputs: `dmem_rdata`=0, `misalign`=0, `tx_valid`=0, `tx_data`=0.
- FIFO state: empty, pointers=0, `overflow`=0.
- RAM contents are not reset.
- Reset overrides any concurrent access; a request in the reset cycle is discarded.

## Timing

- Load latency is 1 cycle: a request sampled at edge N drives `dmem_rdata` after edge N.
- Stores commit at the sampling edge. A load to the same address in the next cycle returns the new data.
- The FIFO state updates at the push/pop edge. STATUS read in the next cycle reflects the change.
- `tx_data` and `tx_valid` are driven from registers or FIFO storage only, with no combinational path from `dmem_*`.
- There are no wait states, and the block never stalls the pipeline.

## Configuration

`DMEM_MISALIGN_TRAP_EN`:
- Defined:
  - An access is misaligned when it is a half access with `a[0]`=1, or a word access with `a[1:0]`≠0.
  - A misaligned store is suppressed.
  - A misaligned load leaves `dmem_rdata` unchanged.
  - `misalign` pulses high for 1 cycle after the sampling edge.
- Undefined:
  - `misalign` is tied to 0.
  - Low address bits below the access size are forced to zero, so the access is naturally aligned and always performed.

## Test plan

- Store word 0xDEADBEEF @0x100; load byte @0x103 with sign-extension → 0xFFFFFFDE; load half @0x100 with zero-extension → 0x0000BEEF.
- Store byte 0x5A @0x101 over 0xDEADBEEF; load word @0x100 → 0xDEAD5AEF.
- Push 8 bytes 0x41..0x48 with `tx_ready`=0; STATUS → 0x18 (count 8, full). Push 0x49; STATUS → 0x58. Store to STATUS; STATUS → 0x18.
- With the FIFO full, drive `tx_ready`=1 and push 0x49 in the same cycle → count stays 8, `overflow` stays 0, bytes drain in order 0x41..0x49.
- Assert `rst_n`=0 mid-drain → the next cycle shows `tx_valid`=0, `dmem_rdata`=0, STATUS=0x20.
- `DMEM_MISALIGN_TRAP_EN` defined: store word 0x12345678 @0x102 → `misalign`=1 for one cycle and word @0x100 unchanged. Undefined: the same store writes word @0x100 = 0x12345678.
